// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I/RV64I instruction decode stage. Takes {instr, pc} from fetch, splits
//   the instruction into register/function fields, builds a sign-extended
//   immediate and registers the result (1-cycle latency). A two-entry buffer
//   (output register + skid register) keeps in_ready a function of registered
//   state only.
//
//   Optional feature macro: DECODE_ILLEGAL_CHECK_EN
//     defined   : out_illegal flags unknown opcodes, bad OP/OP-32 funct7 and
//                 bad shift-immediate encodings. Illegal entries carry only
//                 pc and opcode, and every other field is zero.
//     undefined : out_illegal is tied 0 and no legality logic exists.
//
// Parameters
//   XLEN       datapath width for pc and imm (32 or 64)
//   SUPPORT_M  1: funct7=0000001 on OP/OP-32 is legal, 0: illegal
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush           drops every buffered entry at the next edge
//   in_valid/ready  upstream handshake; in_instr, in_pc payload
//   out_valid/ready downstream handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
//   out_imm, out_is_ecall, out_is_ebreak, out_illegal   decoded payload
//
// Handshake: a beat transfers on any rising edge where valid and ready are
// both 1. A producer holds valid and payload steady until the transfer.
// in_ready never depends on in_valid. The out_* payload stays constant while
// out_valid=1 and out_ready=0.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int SUPPORT_M = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_is_ecall,
  output logic            out_is_ebreak,
  output logic            out_illegal
);

  if ((XLEN != 32 && XLEN != 64) || (SUPPORT_M != 0 && SUPPORT_M != 1)) begin : g_bad_param
    $error("decode_stage: XLEN must be 32 or 64 and SUPPORT_M 0 or 1");
  end

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            is_ecall;
    logic            is_ebreak;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [11:0]     raw_i;
  logic [11:0]     raw_s;
  logic [12:0]     raw_b;
  logic [31:0]     raw_u;
  logic [20:0]     raw_j;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic            is_ecall;
  logic            is_ebreak;
  entry_t          raw_dec;
  entry_t          dec;

  assign opcode = in_instr[6:0];
  assign raw_i  = in_instr[31:20];
  assign raw_s  = {in_instr[31:25], in_instr[11:7]};
  assign raw_b  = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign raw_u  = {in_instr[31:12], 12'b0};
  assign raw_j  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Widening a signed value replicates its top bit up to XLEN.
  assign imm_i = XLEN'($signed(raw_i));
  assign imm_s = XLEN'($signed(raw_s));
  assign imm_b = XLEN'($signed(raw_b));
  assign imm_u = XLEN'($signed(raw_u));
  assign imm_j = XLEN'($signed(raw_j));

  assign is_ecall  = (in_instr == 32'h0000_0073);
  assign is_ebreak = (in_instr == 32'h0010_0073);

  always_comb begin
    raw_dec           = '0;
    raw_dec.pc        = in_pc;
    raw_dec.opcode    = opcode;
    raw_dec.is_ecall  = is_ecall;
    raw_dec.is_ebreak = is_ebreak;
    case (opcode)
      OPC_OP, OPC_OP32: begin
        raw_dec.rd     = in_instr[11:7];
        raw_dec.rs1    = in_instr[19:15];
        raw_dec.rs2    = in_instr[24:20];
        raw_dec.funct3 = in_instr[14:12];
        raw_dec.funct7 = in_instr[31:25];
      end
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_OP_IMM32: begin
        raw_dec.rd     = in_instr[11:7];
        raw_dec.rs1    = in_instr[19:15];
        raw_dec.funct3 = in_instr[14:12];
        raw_dec.imm    = imm_i;
      end
      OPC_STORE: begin
        raw_dec.rs1    = in_instr[19:15];
        raw_dec.rs2    = in_instr[24:20];
        raw_dec.funct3 = in_instr[14:12];
        raw_dec.imm    = imm_s;
      end
      OPC_BRANCH: begin
        raw_dec.rs1    = in_instr[19:15];
        raw_dec.rs2    = in_instr[24:20];
        raw_dec.funct3 = in_instr[14:12];
        raw_dec.imm    = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        raw_dec.rd  = in_instr[11:7];
        raw_dec.imm = imm_u;
      end
      OPC_JAL: begin
        raw_dec.rd  = in_instr[11:7];
        raw_dec.imm = imm_j;
      end
      OPC_SYSTEM: begin
        // ecall/ebreak never write a register.
        raw_dec.rd     = (is_ecall || is_ebreak) ? 5'd0 : in_instr[11:7];
        raw_dec.rs1    = in_instr[19:15];
        raw_dec.funct3 = in_instr[14:12];
        raw_dec.imm    = imm_i;
      end
      default: ;
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic illegal;

  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP32: begin
        illegal = !((in_instr[31:25] == 7'b0000000) ||
                    (in_instr[31:25] == 7'b0100000) ||
                    ((SUPPORT_M == 1) && (in_instr[31:25] == 7'b0000001)));
      end
      OPC_OP_IMM: begin
        // RV64 shifts use a 6-bit shamt, so only funct6 is constrained there.
        if (in_instr[14:12] == 3'b001) begin
          if (XLEN == 64) illegal = (in_instr[31:26] != 6'b000000);
          else            illegal = (in_instr[31:25] != 7'b0000000);
        end else if (in_instr[14:12] == 3'b101) begin
          if (XLEN == 64) illegal = !((in_instr[31:26] == 6'b000000) ||
                                      (in_instr[31:26] == 6'b010000));
          else            illegal = !((in_instr[31:25] == 7'b0000000) ||
                                      (in_instr[31:25] == 7'b0100000));
        end
      end
      OPC_OP_IMM32: begin
        if (in_instr[14:12] == 3'b001) begin
          illegal = (in_instr[31:25] != 7'b0000000);
        end else if (in_instr[14:12] == 3'b101) begin
          illegal = !((in_instr[31:25] == 7'b0000000) ||
                      (in_instr[31:25] == 7'b0100000));
        end
      end
      OPC_LOAD, OPC_AUIPC, OPC_STORE, OPC_LUI, OPC_BRANCH,
      OPC_JALR, OPC_JAL, OPC_SYSTEM: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec = raw_dec;
    if (illegal) begin
      dec         = '0;
      dec.pc      = raw_dec.pc;
      dec.opcode  = raw_dec.opcode;
      dec.illegal = 1'b1;
    end
  end
`else
  assign dec = raw_dec;
`endif

  // ---------------------------------------------------------------------------
  // Output register (entry 0) and skid register (entry 1)
  // ---------------------------------------------------------------------------
  entry_t out_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   skid_valid;
  logic   accept;

  // in_ready depends only on the skid flag and reset, never on in_valid.
  assign in_ready = !skid_valid && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees this edge. The older skid entry goes first. When skid
      // is full in_ready is 0, so no accept can coincide with this move.
      if (skid_valid) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new entry behind it.
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_opcode    = out_q.opcode;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_imm       = out_q.imm;
  assign out_is_ecall  = out_q.is_ecall;
  assign out_is_ebreak = out_q.is_ebreak;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Self-checking bench for decode_stage: directed vectors for reset, decode,
//   back-to-back stall and flush, then randomized traffic scored against a
//   reference decoder built from the instruction-format rules.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam int XLEN      = 32;
  localparam int SUPPORT_M = 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            is_ecall;
    logic            is_ebreak;
    logic            illegal;
  } exp_t;

  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_is_ecall;
  logic            out_is_ebreak;
  logic            out_illegal;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  decode_stage #(.XLEN(XLEN), .SUPPORT_M(SUPPORT_M)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .out_is_ecall(out_is_ecall), .out_is_ebreak(out_is_ebreak), .out_illegal(out_illegal)
  );

  // ---------------- reference model ----------------
  function automatic longint sx(input longint v, input int bits);
    return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    exp_t   e;
    longint w;
    longint f7;
    longint f6;
    longint f3;
    bit     ill;
    w  = longint'({32'b0, ins});
    f7 = (w >> 25) & 127;
    f6 = (w >> 26) & 63;
    f3 = (w >> 12) & 7;
    e = '0;
    e.pc        = pc;
    e.opcode    = ins[6:0];
    e.is_ecall  = (ins == 32'h0000_0073);
    e.is_ebreak = (ins == 32'h0010_0073);
    ill = 1'b0;
    case (ins[6:0])
      7'h33, 7'h3B: begin
        e.rd = 5'(w >> 7); e.rs1 = 5'(w >> 15); e.rs2 = 5'(w >> 20);
        e.funct3 = 3'(f3); e.funct7 = 7'(f7);
        ill = !(f7 == 0 || f7 == 32 || (SUPPORT_M == 1 && f7 == 1));
      end
      7'h03, 7'h13, 7'h67, 7'h1B, 7'h73: begin
        e.rd = 5'(w >> 7); e.rs1 = 5'(w >> 15); e.funct3 = 3'(f3);
        e.imm = XLEN'(sx((w >> 20) & 12'hFFF, 12));
        if (ins[6:0] == 7'h13 && f3 == 1) ill = (XLEN == 64) ? (f6 != 0) : (f7 != 0);
        if (ins[6:0] == 7'h13 && f3 == 5)
          ill = (XLEN == 64) ? !(f6 == 0 || f6 == 16) : !(f7 == 0 || f7 == 32);
        if (ins[6:0] == 7'h1B && f3 == 1) ill = (f7 != 0);
        if (ins[6:0] == 7'h1B && f3 == 5) ill = !(f7 == 0 || f7 == 32);
      end
      7'h23: begin
        e.rs1 = 5'(w >> 15); e.rs2 = 5'(w >> 20); e.funct3 = 3'(f3);
        e.imm = XLEN'(sx((f7 << 5) | ((w >> 7) & 31), 12));
      end
      7'h63: begin
        e.rs1 = 5'(w >> 15); e.rs2 = 5'(w >> 20); e.funct3 = 3'(f3);
        e.imm = XLEN'(sx((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                         (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13));
      end
      7'h37, 7'h17: begin
        e.rd = 5'(w >> 7);
        e.imm = XLEN'(sx(w & 64'hFFFF_F000, 32));
      end
      7'h6F: begin
        e.rd = 5'(w >> 7);
        e.imm = XLEN'(sx((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                         (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21));
      end
      default: ill = 1'b1;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    if (ill) begin
      e = '0;
      e.pc = pc;
      e.opcode = ins[6:0];
      e.illegal = 1'b1;
    end
`else
    if (ill) e.illegal = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r = $urandom();
    sel = $urandom_range(0, 11);
    case (sel)
      0: r[6:0] = 7'h03;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h17;  3: r[6:0] = 7'h1B;
      4: r[6:0] = 7'h23;  5: r[6:0] = 7'h33;  6: r[6:0] = 7'h37;  7: r[6:0] = 7'h3B;
      8: r[6:0] = 7'h63;  9: r[6:0] = 7'h67;  10: r[6:0] = 7'h6F; default: r[6:0] = 7'h73;
    endcase
    sel = $urandom_range(0, 7);
    if (sel < 3) r[31:25] = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'h01;
    sel = $urandom_range(0, 19);
    if (sel == 0) r = 32'h0000_0073;
    if (sel == 1) r = 32'h0010_0073;
`ifdef DECODE_ILLEGAL_CHECK_EN
    if (sel == 2) r = $urandom();
`endif
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [EW-1:0] all_out;
    rst = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00A9_8863;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready cyc=%0d act=%b exp=0", i, in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc=%0d act=%b exp=0", i, out_valid); end
    end
    all_out = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
               out_imm, out_is_ecall, out_is_ebreak, out_illegal};
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_fields act=%h exp=0", all_out); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready act=%b exp=1", in_ready); end
  endtask

  task automatic test_decode_vectors();
    logic [31:0]     v_instr[4] = '{32'h00A9_8863, 32'hFCE0_8793, 32'h0010_00EF, 32'h1234_5037};
    int              v_rd[4]    = '{0, 15, 1, 0};
    int              v_rs1[4]   = '{19, 1, 0, 0};
    int              v_rs2[4]   = '{10, 0, 0, 0};
    longint          v_imm[4]   = '{16, -50, 2048, 64'h1234_5000};
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm_e;
    for (int k = 0; k < 4; k++) begin
      pc = XLEN'(32'h100 + 4 * k);
      imm_e = XLEN'(v_imm[k]);
      @(negedge clk);
      in_valid = 1'b1; in_instr = v_instr[k]; in_pc = pc; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_valid act=%b exp=1", k, out_valid); end
      checks++;
      if (out_pc !== pc) begin errors++; $display("FAIL vec%0d_pc act=%h exp=%h", k, out_pc, pc); end
      checks++;
      if (out_rd !== 5'(v_rd[k])) begin errors++; $display("FAIL vec%0d_rd act=%0d exp=%0d", k, out_rd, v_rd[k]); end
      checks++;
      if (out_rs1 !== 5'(v_rs1[k])) begin errors++; $display("FAIL vec%0d_rs1 act=%0d exp=%0d", k, out_rs1, v_rs1[k]); end
      checks++;
      if (out_rs2 !== 5'(v_rs2[k])) begin errors++; $display("FAIL vec%0d_rs2 act=%0d exp=%0d", k, out_rs2, v_rs2[k]); end
      checks++;
      if (out_funct3 !== 3'd0) begin errors++; $display("FAIL vec%0d_funct3 act=%0d exp=0", k, out_funct3); end
      checks++;
      if (out_imm !== imm_e) begin errors++; $display("FAIL vec%0d_imm act=%h exp=%h", k, out_imm, imm_e); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] pcs[3];
    for (int k = 0; k < 3; k++) pcs[k] = XLEN'(32'h2000 + 4 * k);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = pcs[k];
      #1;
      checks++;
      if (in_ready !== (k < 2)) begin errors++; $display("FAIL b2b_in_ready k=%0d act=%b exp=%b", k, in_ready, k < 2); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_pc !== pcs[0]) begin errors++; $display("FAIL b2b_held_pc act=%h exp=%h", out_pc, pcs[0]); end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[k]) begin
        errors++; $display("FAIL b2b_order k=%0d act_v=%b act_pc=%h exp_pc=%h", k, out_valid, out_pc, pcs[k]);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty act=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic exp_ill;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = 32'h0000_0033; in_pc = XLEN'(32'h3000 + 4 * k);
    end
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_out_valid act=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_in_ready act=%b exp=1", in_ready); end
    // Flush coinciding with an accept into an empty stage drops the input.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_0013;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_out_valid act=%b exp=0", out_valid); end
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hFFFF_FFFF; in_pc = XLEN'(32'h4000);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
`ifdef DECODE_ILLEGAL_CHECK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    checks++;
    if (out_valid !== 1'b1 || out_illegal !== exp_ill || out_opcode !== 7'h7F) begin
      errors++; $display("FAIL all_ones_illegal act_v=%b act_ill=%b act_op=%h exp_ill=%b", out_valid, out_illegal, out_opcode, exp_ill);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    exp_t e;
    exp_t act;
    exp_q.delete();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (c < 790) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 49) == 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end
      in_instr = rand_instr();
      in_pc    = XLEN'({$urandom(), $urandom()});
      #1;
      checks++;
      if (out_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rand_out_valid cyc=%0d act=%b occ=%0d", c, out_valid, exp_q.size());
      end
      checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL rand_in_ready cyc=%0d act=%b occ=%0d", c, in_ready, exp_q.size());
      end
      if (out_valid && out_ready) begin
        checks++;
        act = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
               out_imm, out_is_ecall, out_is_ebreak, out_illegal};
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected_out cyc=%0d act=%h", c, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin errors++; $display("FAIL rand_entry cyc=%0d act=%h exp=%h", c, act, e); end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain act_v=%b left=%0d", out_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_decode_vectors();
    test_back_to_back();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
